// File: rtl/serial_alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU controller: op codes and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_alu_ctrl_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only ADD and SUB propagate a carry/borrow between bit slices.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Bit index for the serial datapath: counts 0..WIDTH-1, saturates, never wraps.
// Latency: index advances one step per cycle with inc; clr takes effect next edge.
// Backpressure: none; inc is ignored once the last index is reached.
// Ports: clk, rst (sync, active-high), clr (restart at 0), inc (advance),
//        idx (current bit index), last (idx == WIDTH-1).
module serial_bit_counter #(
    parameter  int WIDTH = 8,
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [IW-1:0] idx,
    output logic          last
);

    assign last = (idx == IW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc && !last) begin
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: feeds operands LSB-first to an external 1-bit alu slice.
// Latency: start accepted at edge N -> done pulse in cycle N+WIDTH+1 (WIDTH RUN cycles + DONE).
// Backpressure: start is honoured only in IDLE; starts while busy are dropped, not queued.
// Ports: clk, rst (sync, active-high); start/op/opa/opb request an operation;
//        busy/done/result/carry report it; alu_a/alu_b/alu_cin/alu_sel drive the
//        external slice, alu_y/alu_cout return its per-bit result and carry/borrow.
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_sel,
    input  logic             alu_y,
    input  logic             alu_cout
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [2:0]       op_q;
    logic             cy_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] res_final;
    logic [IW-1:0]    idx;
    logic             last;

    assign accept = (state == ST_IDLE) && start;

    serial_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .inc  (state == ST_RUN),
        .idx  (idx),
        .last (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and slice-facing outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_a     = 1'b0;
        alu_b     = 1'b0;
        alu_cin   = 1'b0;
        alu_sel   = op_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                alu_a   = opa_q[idx];
                alu_b   = opb_q[idx];
                alu_cin = cy_q;
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The final bit goes straight into the visible result alongside the shadow
    // bits already collected, so result changes only once per operation.
    always_comb begin
        res_final      = shadow_q;
        res_final[idx] = alu_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= OP_ADD;
            cy_q     <= 1'b0;
            shadow_q <= '0;
            result   <= '0;
            carry    <= 1'b0;
        end else if (accept) begin
            opa_q <= opa;
            opb_q <= opb;
            op_q  <= op;
            cy_q  <= 1'b0;
        end else if (state == ST_RUN) begin
            shadow_q[idx] <= alu_y;
            cy_q          <= is_arith(op_q) ? alu_cout : 1'b0;
            if (last) begin
                result <= res_final;
                carry  <= is_arith(op_q) ? alu_cout : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Bench for serial_alu_ctrl with a behavioural 1-bit alu slice wired in.
// Stimulus issues operations and pushes expected results; a monitor checks each done.
module tb_serial_alu_ctrl;
    import serial_alu_ctrl_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         busy, done, carry;
    logic [W-1:0] result;
    logic         alu_a, alu_b, alu_cin, alu_y, alu_cout;
    logic [2:0]   alu_sel;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_sel  (alu_sel),
        .alu_y    (alu_y),
        .alu_cout (alu_cout)
    );

    always #5 clk = ~clk;

    // 1-bit alu slice.
    always_comb begin
        alu_y    = 1'b0;
        alu_cout = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                alu_y    = alu_a ^ alu_b ^ alu_cin;
                alu_cout = (alu_a & alu_b) | (alu_cin & (alu_a ^ alu_b));
            end
            OP_SUB: begin
                alu_y    = alu_a ^ alu_b ^ alu_cin;
                alu_cout = (~alu_a & (alu_b | alu_cin)) | (alu_b & alu_cin);
            end
            OP_MUL:  alu_y = alu_a & alu_b;
            OP_NOT:  alu_y = ~alu_a;
            OP_AND:  alu_y = alu_a & alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_XOR:  alu_y = alu_a ^ alu_b;
            default: alu_y = ~(alu_a ^ alu_b);
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cy;
        logic [31:0]  at;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    logic [W-1:0] held_res = '0;
    logic         held_cy = 1'b0;
    bit           held_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Word-level reference: what the whole operation should produce.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t     e;
        logic [W:0] s;
        e.res = '0;
        e.cy  = 1'b0;
        e.at  = '0;
        case (o)
            OP_ADD: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0];
                e.cy  = s[W];
            end
            OP_SUB: begin
                e.res = a - b;
                e.cy  = (a < b);
            end
            OP_NOT:  e.res = ~a;
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_XOR:  e.res = a ^ b;
            OP_XNOR: e.res = ~(a ^ b);
            default: e.res = '0;
        endcase
        return e;
    endfunction

    // Monitor: sample just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                held_res = '0;
                held_cy  = 1'b0;
                held_vld = 1'b1;
            end else if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("result", 32'(result), 32'(mon_e.res));
                    chk("carry", 32'(carry), 32'(mon_e.cy));
                    chk("done_cycle", 32'(cyc), mon_e.at);
                    chk("busy_in_done", 32'(busy), 32'd1);
                    held_res = mon_e.res;
                    held_cy  = mon_e.cy;
                end
            end else if (held_vld) begin
                chk("result_held", 32'(result), 32'(held_res));
                chk("carry_held", 32'(carry), 32'(held_cy));
            end
        end
    end

    // Drives one start from IDLE; inputs are scrambled right after acceptance
    // so that only the latched copies can produce the right answer.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noise, input bit expect_done);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        opa   = W'($urandom);
        opb   = W'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (expect_done) begin
            e    = model(o, a, b);
            e.at = cyc + W;
            sbq.push_back(e);
        end
        if (noise) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            op    = 3'($urandom);
            opa   = W'($urandom);
            opb   = W'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < W + 8) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < W + 8) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
        issue(o, a, b, noise, 1'b1);
        wait_done();
        wait_idle();
    endtask

    initial begin
        exp_t    e;
        logic [2:0] o;
        logic [W-1:0] a, b;
        int      k;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_alu_abc", {29'd0, alu_a, alu_b, alu_cin}, 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        rst = 1'b0;

        // Directed cases.
        run(OP_ADD, 8'h5A, 8'h3C, 1'b0);
        run(OP_ADD, 8'hFF, 8'h01, 1'b0);
        run(OP_SUB, 8'h00, 8'h01, 1'b0);
        run(OP_SUB, 8'h10, 8'h01, 1'b0);
        run(OP_XOR, 8'hA5, 8'hFF, 1'b0);
        run(OP_ADD, 8'h01, 8'h01, 1'b1);

        // Start raised during DONE is ignored; held into IDLE it is accepted.
        issue(OP_OR, 8'h12, 8'h48, 1'b0, 1'b1);
        wait_done();
        start = 1'b1;
        op    = OP_AND;
        opa   = 8'hF0;
        opb   = 8'h3C;
        @(negedge clk);
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("start_after_done_accepted", 32'(busy), 32'd1);
        e    = model(OP_AND, 8'hF0, 8'h3C);
        e.at = cyc + W;
        sbq.push_back(e);
        wait_done();
        wait_idle();

        // Reset in the fourth RUN cycle aborts; a start right after reset is accepted.
        issue(OP_ADD, 8'h77, 8'h99, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_carry", 32'(carry), 32'd0);
        chk("abort_alu_abc", {29'd0, alu_a, alu_b, alu_cin}, 32'd0);
        rst   = 1'b0;
        start = 1'b1;
        op    = OP_AND;
        opa   = 8'hF0;
        opb   = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        chk("start_after_rst_accepted", 32'(busy), 32'd1);
        e    = model(OP_AND, 8'hF0, 8'h3C);
        e.at = cyc + W;
        sbq.push_back(e);
        wait_done();
        wait_idle();

        // Randomised operations, including boundary operands and ignored starts.
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 6);
            o = (k < 2) ? 3'(k) : 3'(k + 1);
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(o, a, b, ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
